// File: rtl/mlaccel_cmd_sequencer_if.sv
// Fetch port toward the shared-memory arbiter and command channel toward the compute unit.
// master = sequencer side, slave = memory/compute side.
interface mlaccel_cmd_sequencer_if;
  logic        smem_valid;
  logic        smem_ready;
  logic [15:0] smem_addr;
  logic [31:0] smem_data;
  logic        comp_valid;
  logic        comp_ready;
  logic [31:0] comp_data;

  modport master (
    output smem_valid, smem_addr, comp_valid, comp_data,
    input  smem_ready, smem_data, comp_ready
  );

  modport slave (
    input  smem_valid, smem_addr, comp_valid, comp_data,
    output smem_ready, smem_data, comp_ready
  );
endinterface

// File: rtl/mlaccel_cmd_sequencer.sv
// Command fetch/dispatch: runs jump/loop/halt (and optionally call/return) locally and
// forwards every other word to the compute unit. Define MLACCEL_SEQ_STACK_EN for the return stack.
module mlaccel_cmd_sequencer #(
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned CNT_WIDTH   = 16
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    start,
  input  logic [15:0]             addr,
  input  logic                    stop,
  output logic                    busy,
  output logic                    error,
  mlaccel_cmd_sequencer_if.master bus
);

  typedef enum logic [1:0] {StIdle, StFetch, StIssue, StDrain} state_e;

  localparam logic [7:0] OpJump   = 8'h01;
  localparam logic [7:0] OpCall   = 8'h02;
  localparam logic [7:0] OpRet    = 8'h03;
  localparam logic [7:0] OpSetcnt = 8'h04;
  localparam logic [7:0] OpDjnz   = 8'h05;
  localparam logic [7:0] OpHalt   = 8'h06;

  state_e               state_q, state_d;
  logic [15:0]          pc_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_dec;
  logic [31:0]          cmd_q;
  logic                 abort_q;
  logic [7:0]           op;
  logic [15:0]          imm;
  logic [15:0]          pc_inc;
  logic                 start_ok;
  logic                 fetch_hit;
  logic                 unused_data;

  assign op          = bus.smem_data[7:0];
  assign imm         = bus.smem_data[31:16];
  assign pc_inc      = pc_q + 16'd1;
  assign cnt_dec     = cnt_q - CNT_WIDTH'(1);
  assign start_ok    = (state_q == StIdle) && start;
  // A word returned in the same cycle as stop is dropped, never executed.
  assign fetch_hit   = (state_q == StFetch) && bus.smem_ready && !stop;
  assign unused_data = ^bus.smem_data[15:8];

`ifdef MLACCEL_SEQ_STACK_EN
  localparam int unsigned SpW  = $clog2(STACK_DEPTH + 1);
  localparam int unsigned IdxW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [SpW-1:0] sp_q;
  logic [SpW-1:0] sp_m1;
  logic [15:0]    stack_q [2**IdxW];
  logic           error_q;
  logic           sp_full;
  logic           sp_empty;

  assign sp_m1    = sp_q - SpW'(1);
  assign sp_full  = (sp_q == SpW'(STACK_DEPTH));
  assign sp_empty = (sp_q == '0);
  assign error    = error_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      sp_q    <= '0;
      error_q <= 1'b0;
    end else if (start_ok) begin
      sp_q    <= '0;
      error_q <= 1'b0;
    end else if (fetch_hit && (op == OpCall)) begin
      if (sp_full) begin
        error_q <= 1'b1;
      end else begin
        stack_q[sp_q[IdxW-1:0]] <= pc_inc;
        sp_q                    <= sp_q + SpW'(1);
      end
    end else if (fetch_hit && (op == OpRet) && !sp_empty) begin
      sp_q <= sp_m1;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = (STACK_DEPTH == 0);
  assign error      = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start) state_d = StFetch;
      end
      StFetch: begin
        if (stop) begin
          state_d = bus.smem_ready ? StIdle : StDrain;
        end else if (bus.smem_ready) begin
          case (op)
            OpJump, OpSetcnt, OpDjnz: state_d = StFetch;
            OpHalt:                   state_d = StIdle;
`ifdef MLACCEL_SEQ_STACK_EN
            OpCall:                   state_d = sp_full ? StIdle : StFetch;
            OpRet:                    state_d = sp_empty ? StIdle : StFetch;
`else
            OpCall, OpRet:            state_d = StIdle;
`endif
            default:                  state_d = StIssue;
          endcase
        end
      end
      StIssue: begin
        if (bus.comp_ready) state_d = (abort_q || stop) ? StIdle : StFetch;
      end
      StDrain: begin
        if (bus.smem_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    busy           = (state_q != StIdle);
    bus.smem_valid = (state_q == StFetch) || (state_q == StDrain);
    bus.smem_addr  = pc_q;
    bus.comp_valid = (state_q == StIssue);
    bus.comp_data  = cmd_q;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= '0;
      cnt_q   <= '0;
      cmd_q   <= '0;
      abort_q <= 1'b0;
    end else begin
      if (start_ok) begin
        pc_q    <= addr;
        abort_q <= 1'b0;
      end else if (stop && (state_q != StIdle)) begin
        abort_q <= 1'b1;
      end
      if (fetch_hit) begin
        case (op)
          OpJump: pc_q <= imm;
          OpSetcnt: begin
            cnt_q <= imm;
            pc_q  <= pc_inc;
          end
          OpDjnz: begin
            cnt_q <= cnt_dec;
            pc_q  <= (cnt_dec != '0) ? imm : pc_inc;
          end
          OpHalt: begin
          end
`ifdef MLACCEL_SEQ_STACK_EN
          OpCall: begin
            if (!sp_full) pc_q <= imm;
          end
          OpRet: begin
            if (!sp_empty) pc_q <= stack_q[sp_m1[IdxW-1:0]];
          end
`else
          OpCall, OpRet: begin
          end
`endif
          default: begin
            cmd_q <= bus.smem_data;
            pc_q  <= pc_inc;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mlaccel_cmd_sequencer.sv
// Directed bench for mlaccel_cmd_sequencer: memory/arbiter responder, transfer monitor and
// one task per scenario with hand-computed expectations.
module tb_mlaccel_cmd_sequencer;
  logic        clock = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] addr;
  logic        stop;
  logic        busy;
  logic        error;

  mlaccel_cmd_sequencer_if bus ();

  mlaccel_cmd_sequencer #(.STACK_DEPTH(4), .CNT_WIDTH(16)) dut (
    .clock (clock),
    .reset (reset),
    .start (start),
    .addr  (addr),
    .stop  (stop),
    .busy  (busy),
    .error (error),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  int          checks   = 0;
  int          failures = 0;
  int unsigned arb_delay = 2;
  logic [31:0] mem [logic [15:0]];
  logic [31:0] comp_q [$];
  logic [15:0] fetch_q [$];

  function automatic logic [31:0] mem_rd(input logic [15:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'h0000_0006;
  endfunction

  // Arbiter: grants immediately, returns data arb_delay cycles later as a one-cycle pulse.
  initial begin
    logic [15:0] a;
    bus.smem_ready = 1'b0;
    bus.smem_data  = '0;
    forever begin
      if (bus.smem_valid === 1'b1 && reset === 1'b0) begin
        a = bus.smem_addr;
        repeat (arb_delay) @(posedge clock);
        #1;
        bus.smem_ready = 1'b1;
        bus.smem_data  = mem_rd(a);
        @(posedge clock);
        #1;
        bus.smem_ready = 1'b0;
      end else begin
        @(posedge clock);
        #1;
      end
    end
  end

  // Monitor records handshakes that complete at the next rising edge.
  initial begin
    forever begin
      @(negedge clock);
      #1;
      if (reset === 1'b0) begin
        if (bus.comp_valid === 1'b1 && bus.comp_ready === 1'b1) comp_q.push_back(bus.comp_data);
        if (bus.smem_valid === 1'b1 && bus.smem_ready === 1'b1) fetch_q.push_back(bus.smem_addr);
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clear_env();
    mem.delete();
    comp_q.delete();
    fetch_q.delete();
  endtask

  task automatic pulse_start(input logic [15:0] a);
    start = 1'b1;
    addr  = a;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int n);
    for (int i = 0; i < n && busy !== 1'b0; i++) @(negedge clock);
    repeat (2) @(negedge clock);
  endtask

  task automatic wait_comp_valid(input int n);
    for (int i = 0; i < n && bus.comp_valid !== 1'b1; i++) @(negedge clock);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, error, bus.smem_valid, bus.comp_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_in: got %b expected 0000", {busy, error, bus.smem_valid, bus.comp_valid});
    end
    reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({busy, error, bus.smem_valid, bus.comp_valid} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_out: got %b expected 0000", {busy, error, bus.smem_valid, bus.comp_valid});
    end
  endtask

  task automatic test_latency();
    clear_env();
    mem[16'h0100] = 32'h0000_0010;
    mem[16'h0101] = 32'h0000_0006;
    bus.comp_ready = 1'b1;
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL stop_idle: busy got %b expected 0", busy);
    end
    pulse_start(16'h0100);
    checks++;
    if (bus.smem_valid !== 1'b1 || bus.smem_addr !== 16'h0100 || busy !== 1'b1) begin
      failures++;
      $display("FAIL lat_c1: valid=%b addr=%h busy=%b expected 1 0100 1",
               bus.smem_valid, bus.smem_addr, busy);
    end
    repeat (2) @(negedge clock);
    checks++;
    if (bus.comp_valid !== 1'b0) begin
      failures++;
      $display("FAIL lat_c3: comp_valid got %b expected 0", bus.comp_valid);
    end
    @(negedge clock);
    checks++;
    if (bus.comp_valid !== 1'b1 || bus.comp_data !== 32'h0000_0010) begin
      failures++;
      $display("FAIL lat_c4: comp_valid=%b data=%h expected 1 00000010",
               bus.comp_valid, bus.comp_data);
    end
    wait_idle(100);
    checks++;
    if (busy !== 1'b0 || comp_q.size() != 1 || comp_q[0] !== 32'h0000_0010) begin
      failures++;
      $display("FAIL lat_xfer: busy=%b n=%0d expected busy 0 one transfer 00000010",
               busy, comp_q.size());
    end
    checks++;
    if (fetch_q.size() != 2 || fetch_q[0] !== 16'h0100 || fetch_q[1] !== 16'h0101) begin
      failures++;
      $display("FAIL lat_addrs: n=%0d expected 2 fetches 0100,0101", fetch_q.size());
    end
  endtask

  task automatic test_loop();
    int bad;
    clear_env();
    mem[16'h0300] = 32'h0003_0004;
    mem[16'h0301] = 32'h0000_0020;
    mem[16'h0302] = 32'h0301_0005;
    mem[16'h0303] = 32'h0000_0006;
    bus.comp_ready = 1'b1;
    pulse_start(16'h0300);
    wait_idle(300);
    bad = 0;
    foreach (comp_q[i]) if (comp_q[i] !== 32'h0000_0020) bad++;
    checks++;
    if (comp_q.size() != 3 || bad != 0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL loop_xfer: n=%0d bad=%0d busy=%b expected 3 0 0", comp_q.size(), bad, busy);
    end
    checks++;
    if (fetch_q.size() != 8) begin
      failures++;
      $display("FAIL loop_fetches: got %0d expected 8", fetch_q.size());
    end
  endtask

  task automatic test_call();
    bus.comp_ready = 1'b1;
`ifdef MLACCEL_SEQ_STACK_EN
    clear_env();
    mem[16'h0400] = 32'h0200_0002;
    mem[16'h0401] = 32'h0000_0031;
    mem[16'h0402] = 32'h0000_0006;
    mem[16'h0200] = 32'h0000_0030;
    mem[16'h0201] = 32'h0000_0003;
    pulse_start(16'h0400);
    wait_idle(300);
    checks++;
    if (comp_q.size() != 2 || comp_q[0] !== 32'h30 || comp_q[1] !== 32'h31 || error !== 1'b0) begin
      failures++;
      $display("FAIL call_order: n=%0d error=%b expected 2 transfers 30,31 error 0",
               comp_q.size(), error);
    end
    checks++;
    if (fetch_q.size() != 5) begin
      failures++;
      $display("FAIL call_fetches: got %0d expected 5", fetch_q.size());
    end
    clear_env();
    for (int i = 0; i < 5; i++) mem[16'h0600 + 16'(i)] = {16'h0601 + 16'(i), 16'h0002};
    pulse_start(16'h0600);
    wait_idle(300);
    checks++;
    if (error !== 1'b1 || busy !== 1'b0 || fetch_q.size() != 5) begin
      failures++;
      $display("FAIL call_overflow: error=%b busy=%b fetches=%0d expected 1 0 5",
               error, busy, fetch_q.size());
    end
    begin
      int seen = 0;
      repeat (5) begin
        @(negedge clock);
        if (bus.smem_valid !== 1'b0) seen++;
      end
      checks++;
      if (seen != 0) begin
        failures++;
        $display("FAIL overflow_quiet: smem_valid cycles got %0d expected 0", seen);
      end
    end
`else
    clear_env();
    mem[16'h0400] = 32'h0000_0011;
    mem[16'h0401] = 32'h0500_0002;
    mem[16'h0500] = 32'h0000_0012;
    pulse_start(16'h0400);
    wait_idle(300);
    checks++;
    if (comp_q.size() != 1 || comp_q[0] !== 32'h11 || fetch_q.size() != 2 || busy !== 1'b0) begin
      failures++;
      $display("FAIL call_as_halt: n=%0d fetches=%0d busy=%b expected 1 2 0",
               comp_q.size(), fetch_q.size(), busy);
    end
    clear_env();
    mem[16'h0410] = 32'h0000_0003;
    pulse_start(16'h0410);
    wait_idle(300);
    checks++;
    if (comp_q.size() != 0 || fetch_q.size() != 1 || error !== 1'b0) begin
      failures++;
      $display("FAIL ret_as_halt: n=%0d fetches=%0d error=%b expected 0 1 0",
               comp_q.size(), fetch_q.size(), error);
    end
`endif
  endtask

  task automatic test_backpressure();
    int drop, chg, fetch_seen;
    clear_env();
    mem[16'h0700] = 32'hABCD_0077;
    bus.comp_ready = 1'b0;
    pulse_start(16'h0700);
    wait_comp_valid(50);
    checks++;
    if (bus.comp_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_valid: comp_valid got %b expected 1", bus.comp_valid);
    end
    drop = 0; chg = 0; fetch_seen = 0;
    repeat (10) begin
      @(negedge clock);
      if (bus.comp_valid !== 1'b1) drop++;
      if (bus.comp_data !== 32'hABCD_0077) chg++;
      if (bus.smem_valid !== 1'b0) fetch_seen++;
    end
    checks++;
    if (drop != 0 || chg != 0) begin
      failures++;
      $display("FAIL bp_stable: drops=%0d data_changes=%0d expected 0 0", drop, chg);
    end
    checks++;
    if (fetch_seen != 0) begin
      failures++;
      $display("FAIL bp_no_fetch: smem_valid cycles got %0d expected 0", fetch_seen);
    end
    bus.comp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.comp_valid !== 1'b0 || bus.smem_valid !== 1'b1) begin
      failures++;
      $display("FAIL bp_release: comp_valid=%b smem_valid=%b expected 0 1",
               bus.comp_valid, bus.smem_valid);
    end
    wait_idle(100);
    checks++;
    if (comp_q.size() != 1 || comp_q[0] !== 32'hABCD_0077) begin
      failures++;
      $display("FAIL bp_xfer: n=%0d expected 1 transfer abcd0077", comp_q.size());
    end
  endtask

  task automatic test_stop_fetch();
    int bad;
    logic seen;
    clear_env();
    mem[16'h0800] = 32'h0000_0040;
    bus.comp_ready = 1'b1;
    arb_delay = 5;
    pulse_start(16'h0800);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    bad = 0;
    seen = 1'b0;
    for (int i = 0; i < 12 && !seen; i++) begin
      if (bus.smem_valid !== 1'b1 || bus.comp_valid !== 1'b0) bad++;
      if (bus.smem_ready === 1'b1) seen = 1'b1;
      else @(negedge clock);
    end
    checks++;
    if (bad != 0 || !seen) begin
      failures++;
      $display("FAIL stopf_hold: bad_cycles=%0d ready_seen=%b expected 0 1", bad, seen);
    end
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || bus.smem_valid !== 1'b0) begin
      failures++;
      $display("FAIL stopf_idle: busy=%b smem_valid=%b expected 0 0", busy, bus.smem_valid);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (comp_q.size() != 0) begin
      failures++;
      $display("FAIL stopf_nocmd: transfers got %0d expected 0", comp_q.size());
    end
    arb_delay = 2;
  endtask

  task automatic test_stop_issue();
    int drop;
    clear_env();
    mem[16'h0900] = 32'h0000_0050;
    mem[16'h0901] = 32'h0000_0051;
    bus.comp_ready = 1'b0;
    pulse_start(16'h0900);
    wait_comp_valid(50);
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    drop = 0;
    repeat (3) begin
      @(negedge clock);
      if (bus.comp_valid !== 1'b1 || bus.comp_data !== 32'h0000_0050) drop++;
    end
    checks++;
    if (drop != 0) begin
      failures++;
      $display("FAIL stopi_hold: bad_cycles got %0d expected 0", drop);
    end
    bus.comp_ready = 1'b1;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0 || bus.smem_valid !== 1'b0) begin
      failures++;
      $display("FAIL stopi_idle: busy=%b smem_valid=%b expected 0 0", busy, bus.smem_valid);
    end
    repeat (3) @(negedge clock);
    checks++;
    if (comp_q.size() != 1 || comp_q[0] !== 32'h0000_0050 || fetch_q.size() != 1) begin
      failures++;
      $display("FAIL stopi_xfer: n=%0d fetches=%0d expected 1 transfer 00000050, 1 fetch",
               comp_q.size(), fetch_q.size());
    end
  endtask

  task automatic test_reset_issue();
    int noisy;
    clear_env();
    mem[16'h0A00] = 32'h0000_0060;
    bus.comp_ready = 1'b0;
    pulse_start(16'h0A00);
    wait_comp_valid(50);
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (bus.comp_valid !== 1'b0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_issue: comp_valid=%b busy=%b expected 0 0", bus.comp_valid, busy);
    end
    reset = 1'b0;
    arb_delay = 4;
    pulse_start(16'h0A00);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    noisy = 0;
    repeat (8) begin
      @(negedge clock);
      if (bus.smem_valid !== 1'b0 || bus.comp_valid !== 1'b0 || busy !== 1'b0) noisy++;
    end
    checks++;
    if (noisy != 0) begin
      failures++;
      $display("FAIL stray_ready: active cycles got %0d expected 0", noisy);
    end
    arb_delay = 2;
    clear_env();
    mem[16'h0A00] = 32'h0000_0060;
    bus.comp_ready = 1'b1;
    pulse_start(16'h0A00);
    wait_idle(100);
    checks++;
    if (comp_q.size() != 1 || comp_q[0] !== 32'h0000_0060 || fetch_q.size() != 2) begin
      failures++;
      $display("FAIL rst_restart: n=%0d fetches=%0d expected 1 transfer 00000060, 2 fetches",
               comp_q.size(), fetch_q.size());
    end
  endtask

  task automatic test_start_stop_same_cycle();
    clear_env();
    mem[16'h0B00] = 32'h0000_0070;
    bus.comp_ready = 1'b1;
    stop = 1'b1;
    pulse_start(16'h0B00);
    stop = 1'b0;
    wait_idle(100);
    checks++;
    if (comp_q.size() != 1 || comp_q[0] !== 32'h0000_0070) begin
      failures++;
      $display("FAIL start_wins: transfers got %0d expected 1 of 00000070", comp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    addr  = '0;
    bus.comp_ready = 1'b0;
    test_reset();
    test_latency();
    test_loop();
    test_call();
    test_backpressure();
    test_stop_fetch();
    test_stop_issue();
    test_reset_issue();
    test_start_stop_same_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mlaccel_cmd_sequencer.md
Name: mlaccel_cmd_sequencer

Overview:
Instruction fetch/dispatch stage between the host command machine and the compute unit. On a start pulse it fetches 32-bit words from main memory through the shared-memory arbiter port, starting at a 16-bit word address. Control opcodes (jump, call/return, counted loop, halt) execute locally. All other words are forwarded unchanged to the compute unit over a valid/ready command channel. busy is OR-ed with compute busy to form the host-visible status.

Parameters:
STACK_DEPTH, 4, return-address stack entries (1..8)
CNT_WIDTH, 16, loop counter width (fixed at 16; the SETCNT operand is 16 bits)

Ports:
clock  input  1  system clock
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse; begin execution at addr
addr  input  16  start word address, sampled with start
stop  input  1  one-cycle pulse; abort execution
busy  output  1  sequencer active
error  output  1  sticky: stack overflow seen
smem_valid  output  1  fetch request
smem_ready  input  1  fetch data valid (one-cycle pulse)
smem_addr  output  16  fetch word address
smem_data  input  32  fetched word, valid while smem_ready=1
comp_valid  output  1  compute command valid
comp_ready  input  1  compute command accepted
comp_data  output  32  compute command word

Behaviour:
- Reset (takes priority over everything else, same cycle):
  - busy=0, smem_valid=0, comp_valid=0, error=0, state=IDLE, stack pointer=0, loop counter=0.
  - comp_data/smem_addr are don't-care.
- States: IDLE, FETCH, ISSUE, DRAIN.
- IDLE:
  - start -> pc<=addr, error<=0, go to FETCH.
  - stop in IDLE is ignored.
- FETCH:
  - smem_valid=1, smem_addr=pc.
  - smem_valid/smem_addr held stable until smem_ready. The request is never withdrawn early, because the arbiter may already have granted it.
  - The arbiter returns smem_ready 2 cycles after grant.
- Decode happens in the smem_ready cycle, on op=smem_data[7:0] and imm=smem_data[31:16]:
  - 0x01 JUMP: pc<=imm; stay FETCH.
  - 0x02 CALL: if sp==STACK_DEPTH, error<=1 and go to IDLE. Else push pc+1, pc<=imm, stay FETCH.
  - 0x03 RET: if sp==0, go to IDLE (normal end). Else pop into pc, stay FETCH.
  - 0x04 SETCNT: cnt<=imm, pc<=pc+1.
  - 0x05 DJNZ: cnt<=cnt-1 (wraps 0->FFFF). If cnt-1 != 0, pc<=imm, else pc<=pc+1.
  - 0x06 HALT: go to IDLE.
  - Any other op: comp_data<=smem_data, pc<=pc+1, go to ISSUE.
- Fetch timing:
  - Control ops present the next smem_addr the cycle after smem_ready.
  - smem_valid may stay high across consecutive fetches.
- ISSUE:
  - comp_valid=1 from the cycle after decode.
  - comp_data is held until comp_ready, and comp_valid is not withdrawn before then.
  - On comp_ready: comp_valid drops next cycle and state goes to FETCH, so smem_valid rises the cycle after comp_ready.
- Address arithmetic: pc, stack entries and imm are 16-bit; pc+1 wraps FFFF->0000.
- stop:
  - Sets an abort flag.
  - In FETCH: the state goes to DRAIN and keeps the pending request until smem_ready. The returned word is discarded, then IDLE.
  - In ISSUE: the current command is held until comp_ready, then IDLE. No further fetch.
  - stop and start in the same cycle while IDLE: start wins.
- busy: 1 in every state except IDLE, including the IDLE-entry cycle's outputs settling. busy=0 the cycle after entering IDLE.
- start while busy: ignored.
- Reset mid-fetch: a later stray smem_ready while IDLE is ignored.
- Example latency with an idle arbiter: start at cycle 0, smem_valid cycle 1, smem_ready cycle 3, comp_valid cycle 4.

Optional Feature:
MLACCEL_SEQ_STACK_EN:
- Defined: CALL/RET and the return stack behave as above; error reports overflow.
- Undefined: no stack storage; CALL and RET both decode as HALT; error is tied 0.

Test Plan:
- Memory: 0x100 = 0x0000_0010, 0x101 = 0x0000_0006. start with addr=0x0100, comp_ready tied 1 -> exactly one comp transfer with data 0x00000010; busy falls; smem_addr sequence 0100, 0101.
- Loop: SETCNT 3; body word 0x0000_0020; DJNZ back to body; HALT -> three comp transfers of 0x00000020, then busy=0.
- Call: CALL 0x0200; 0x200 = compute word then RET; after the call site, compute word then HALT -> comp order correct; error=0. Nesting 5 deep with STACK_DEPTH=4 -> error=1, busy=0, no further smem_valid.
- Backpressure: comp_ready held low 10 cycles -> comp_valid and comp_data stable throughout; no smem_valid during the stall; one transfer when ready rises.
- Stop during fetch (smem_ready delayed 5 cycles) -> smem_valid held until ready, no comp_valid, busy=0 after. Stop during ISSUE -> pending command still transferred, then idle.
- Reset asserted in ISSUE with comp_valid=1 -> next cycle comp_valid=0, busy=0; a subsequent start works normally.
